// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, redirect flush/bubble and EX forwarding control
//
// Tracks the instructions in EX, MEM and WB as small shadow records and
// derives the pipeline hazard controls from them and the ID control bundle.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1, id_rs2, id_rd    ID register fields
//   id_valid_reg             {rs2, rs1, rd} field validity from decode
//   id_reg_write             ID instruction writes the RegFile
//   id_mem_read              ID instruction is a load
//   ex_redirect              taken branch / jump resolved in EX
//   stall                    hold PC and IF/ID (combinational)
//   flush_id                 clear IF/ID at this edge (combinational)
//   bubble_ex                load a NOP into ID/EX at this edge (combinational)
//   fwd_a, fwd_b             EX operand source: 0 RegFile, 1 EX/MEM, 2 MEM/WB
//   stall_count, flush_count saturating event counters
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_valid_reg,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } shadow_t;

  localparam shadow_t          SHADOW_EMPTY = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0, mem_read: 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [1:0]       SEL_RF       = 2'd0;
  localparam logic [1:0]       SEL_EX       = 2'd1;
  localparam logic [1:0]       SEL_MEM      = 2'd2;

  shadow_t ex_sh, mem_sh, wb_sh;

  logic       src1, src2;
  logic       ex_prod, mem_prod;
  logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic       load_use;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // The rd validity bit is implied by reg_write for producers; the WB
  // record is kept for visibility only since the RegFile is write-before-read.
  logic unused_ok;
  assign unused_ok = id_valid_reg[0] ^ (|wb_sh);

  always_comb begin
    src1     = id_valid_reg[1] && (id_rs1 != 5'd0);
    src2     = id_valid_reg[2] && (id_rs2 != 5'd0);

    ex_prod  = ex_sh.valid  && ex_sh.reg_write  && (ex_sh.rd  != 5'd0);
    mem_prod = mem_sh.valid && mem_sh.reg_write && (mem_sh.rd != 5'd0);

    ex_hit1  = ex_prod  && src1 && (ex_sh.rd  == id_rs1);
    ex_hit2  = ex_prod  && src2 && (ex_sh.rd  == id_rs2);
    mem_hit1 = mem_prod && src1 && (mem_sh.rd == id_rs1);
    mem_hit2 = mem_prod && src2 && (mem_sh.rd == id_rs2);

    load_use = id_valid && ex_sh.mem_read && (ex_hit1 || ex_hit2);

    // Redirect wins over load-use: the dependent instruction is squashed anyway.
    stall     = load_use && !ex_redirect;
    flush_id  = ex_redirect;
    bubble_ex = ex_redirect || load_use;

    // A load in EX is never a forwarding source; that case is bubbled above.
    fwd_a_nxt = SEL_RF;
    if (ex_hit1 && !ex_sh.mem_read) fwd_a_nxt = SEL_EX;
    else if (mem_hit1)              fwd_a_nxt = SEL_MEM;

    fwd_b_nxt = SEL_RF;
    if (ex_hit2 && !ex_sh.mem_read) fwd_b_nxt = SEL_EX;
    else if (mem_hit2)              fwd_b_nxt = SEL_MEM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_sh       <= SHADOW_EMPTY;
      mem_sh      <= SHADOW_EMPTY;
      wb_sh       <= SHADOW_EMPTY;
      fwd_a       <= SEL_RF;
      fwd_b       <= SEL_RF;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      wb_sh  <= mem_sh;
      mem_sh <= ex_sh;

      if (bubble_ex || !id_valid) begin
        ex_sh <= SHADOW_EMPTY;
      end else begin
        ex_sh.valid     <= 1'b1;
        ex_sh.rd        <= id_rd;
        ex_sh.reg_write <= id_reg_write;
        ex_sh.mem_read  <= id_mem_read;
      end

      if (bubble_ex || !id_valid) begin
        fwd_a <= SEL_RF;
        fwd_b <= SEL_RF;
      end else if (!stall) begin
        fwd_a <= fwd_a_nxt;
        fwd_b <= fwd_b_nxt;
      end

      if (stall && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_ONE;
      if (flush_id && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit against an in-flight instruction model
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0] id_valid_reg = '0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, ex_redirect = 1'b0;

  logic        stall, flush_id, bubble_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count, flush_count;

  logic        s_stall, s_flush_id, s_bubble_ex;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_count, s_flush_count;

  hazard_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_valid_reg(id_valid_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_redirect(ex_redirect), .stall(stall),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_valid_reg(id_valid_reg), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .ex_redirect(ex_redirect), .stall(s_stall),
    .flush_id(s_flush_id), .bubble_ex(s_bubble_ex), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-flight instructions ahead of ID, youngest first.
  typedef struct { bit v; int rd; bit rw; bit mr; } ent_t;
  typedef struct { bit st; bit fl; bit bu; int fa; int fb; int sc; int fc; } exp_t;

  ent_t m_pipe[3];
  int   m_fa, m_fb, m_sc, m_fc;
  exp_t sb[$];
  bit   last_stall, last_flush;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{v: 0, rd: 0, rw: 0, mr: 0};
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endfunction

  // Who supplies register r: 0 RegFile, 1 ALU result in EX, 2 instruction in MEM,
  // 3 load still in EX (must wait). The nearest older writer wins.
  function automatic int producer(input int r);
    for (int i = 0; i < 2; i++)
      if (m_pipe[i].v && m_pipe[i].rw && m_pipe[i].rd != 0 && m_pipe[i].rd == r)
        return (i == 0) ? (m_pipe[i].mr ? 3 : 1) : 2;
    return 0;
  endfunction

  function automatic int sat4(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                       input bit [2:0] mask, input bit rw, input bit mr, input bit redir);
    int   p1, p2;
    bit   lu;
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_valid_reg = mask; id_reg_write = rw; id_mem_read = mr; ex_redirect = redir;
    p1 = (mask[1] && rs1 != 0) ? producer(rs1) : 0;
    p2 = (mask[2] && rs2 != 0) ? producer(rs2) : 0;
    lu = v && (p1 == 3 || p2 == 3);
    e.st = lu && !redir;
    e.fl = redir;
    e.bu = redir || lu;
    e.fa = m_fa; e.fb = m_fb; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    last_stall = e.st;
    last_flush = e.fl;
    // state after the coming edge
    if (e.st) m_sc++;
    if (e.fl) m_fc++;
    if (e.bu || !v) begin
      m_fa = 0; m_fb = 0;
    end else begin
      m_fa = p1; m_fb = p2;
    end
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    if (v && !e.bu) m_pipe[0] = '{v: 1, rd: rd, rw: rw, mr: mr};
    else            m_pipe[0] = '{v: 0, rd: 0, rw: 0, mr: 0};
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 3'b000, 0, 0, 0);
  endtask

  // Assert reset between edges and look at the outputs straight away.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    last_stall = 0;
    last_flush = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
  endtask

  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m = sb.pop_front();
        chk("stall", stall, m.st);
        chk("flush_id", flush_id, m.fl);
        chk("bubble_ex", bubble_ex, m.bu);
        chk("fwd_a", fwd_a, m.fa);
        chk("fwd_b", fwd_b, m.fb);
        chk("stall_count", stall_count, m.sc);
        chk("flush_count", flush_count, m.fc);
        chk("sat_ctrl", {s_stall, s_flush_id, s_bubble_ex, s_fwd_a, s_fwd_b},
            {m.st, m.fl, m.bu, 2'(m.fa), 2'(m.fb)});
        chk("sat_stall_count", s_stall_count, sat4(m.sc));
        chk("sat_flush_count", s_flush_count, sat4(m.fc));
      end
    end
  end

  bit   c_v, c_rw, c_mr;
  int   c_rs1, c_rs2, c_rd;
  bit [2:0] c_mask;

  initial begin
    model_reset();
    last_stall = 0;
    last_flush = 0;
    #2;
    chk("reset_stall", stall, 0);
    chk("reset_fwd", {fwd_a, fwd_b}, 0);
    chk("reset_counts", stall_count + flush_count, 0);
    repeat (2) @(posedge clk);

    // lw x5 ; add x6,x5,x7 -> one stall, then fwd_a = 2
    issue(1, 1, 0, 5, 3'b011, 1, 1, 0);
    issue(1, 5, 7, 6, 3'b111, 1, 0, 0);
    @(negedge clk);
    chk("lu_stall", stall, 1);
    issue(1, 5, 7, 6, 3'b111, 1, 0, 0);
    @(negedge clk);
    chk("lu_no_second_stall", stall, 0);
    nop();
    @(negedge clk);
    chk("lu_fwd_a", fwd_a, 2);
    chk("lu_stall_count", stall_count, 1);

    // add x5 ; sub x8,x7,x5 -> fwd_b = 1, fwd_a = 0
    issue(1, 1, 2, 5, 3'b111, 1, 0, 0);
    issue(1, 7, 5, 8, 3'b111, 1, 0, 0);
    @(negedge clk);
    chk("alu_no_stall", stall, 0);
    nop();
    @(negedge clk);
    chk("alu_fwd_b", fwd_b, 1);
    chk("alu_fwd_a", fwd_a, 0);

    // one-instruction gap -> fwd_b = 2
    issue(1, 1, 2, 5, 3'b111, 1, 0, 0);
    nop();
    issue(1, 7, 5, 8, 3'b111, 1, 0, 0);
    nop();
    @(negedge clk);
    chk("gap_fwd_b", fwd_b, 2);

    // load to x0 then use of x0; lui after a load to the same rd number
    issue(1, 1, 0, 0, 3'b011, 1, 1, 0);
    issue(1, 0, 0, 6, 3'b011, 1, 0, 0);
    @(negedge clk);
    chk("x0_no_stall", stall, 0);
    issue(1, 1, 0, 9, 3'b011, 1, 1, 0);
    issue(1, 9, 9, 9, 3'b001, 1, 0, 0);
    @(negedge clk);
    chk("lui_no_stall", stall, 0);

    // redirect during load-use
    issue(1, 1, 0, 5, 3'b011, 1, 1, 0);
    issue(1, 5, 7, 6, 3'b111, 1, 0, 1);
    @(negedge clk);
    chk("redir_flush", flush_id, 1);
    chk("redir_bubble", bubble_ex, 1);
    chk("redir_stall", stall, 0);
    nop();
    @(negedge clk);
    chk("redir_stall_count", stall_count, 1);
    chk("redir_flush_count", flush_count, 1);

    // reset mid-stall with a load in EX
    issue(1, 1, 0, 5, 3'b011, 1, 1, 0);
    issue(1, 5, 7, 6, 3'b111, 1, 0, 0);
    async_reset();
    issue(1, 5, 7, 6, 3'b111, 1, 0, 0);
    @(negedge clk);
    chk("post_rst_no_stall", stall, 0);

    // 20 load-use stalls: the 4-bit counter pins at 15
    for (int i = 0; i < 20; i++) begin
      issue(1, 1, 0, 5, 3'b011, 1, 1, 0);
      issue(1, 7, 5, 6, 3'b111, 1, 0, 0);
    end
    nop();
    @(negedge clk);
    chk("sat_hold_15", s_stall_count, 15);
    chk("wide_count_20", stall_count, 20);

    // random front end: held on stall, emptied on flush
    c_v = 0; c_rs1 = 0; c_rs2 = 0; c_rd = 0; c_mask = 0; c_rw = 0; c_mr = 0;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        if (last_flush) begin
          c_v = 0;
        end else begin
          c_v    = ($urandom_range(0, 9) != 0);
          c_rs1  = $urandom_range(0, 3);
          c_rs2  = $urandom_range(0, 3);
          c_rd   = $urandom_range(0, 3);
          c_mask = 3'($urandom_range(0, 7));
          c_mr   = ($urandom_range(0, 2) == 0);
          c_rw   = c_mr || ($urandom_range(0, 3) != 0);
        end
      end
      issue(c_v, c_rs1, c_rs2, c_rd, c_mask, c_rw, c_mr, $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
